// File: rtl/mlp_result_drain.sv
// Captures one MLP result frame, packs Pack elements per beat and drains them on a valid/ready stream.
// Optional ReLU on each element before packing when MLP_DRAIN_RELU_EN is defined.
module mlp_result_drain #(
   parameter int DataWidth = 8,
   parameter int FrameLen  = 256,
   parameter int Pack      = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      result_valid_i,
   input  logic [DataWidth-1:0]      result_data_i,
   output logic                      frame_ready_o,
   output logic                      out_valid_o,
   input  logic                      out_ready_i,
   output logic [Pack*DataWidth-1:0] out_data_o,
   output logic                      out_last_o,
   output logic                      overflow_o
);

   localparam int Depth = FrameLen / Pack;
   localparam int AW    = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int CW    = $clog2(Depth + 1);
   localparam int EW    = (FrameLen > 1) ? $clog2(FrameLen) : 1;
   localparam int LW    = (Pack > 1) ? $clog2(Pack) : 1;
   localparam int BW    = Pack * DataWidth;

   localparam logic [AW-1:0] LastPtr  = AW'(Depth - 1);
   localparam logic [EW-1:0] LastElem = EW'(FrameLen - 1);
   localparam logic [LW-1:0] LastLane = LW'(Pack - 1);

   localparam logic [1:0] StIdle    = 2'd0;
   localparam logic [1:0] StCollect = 2'd1;
   localparam logic [1:0] StFlush   = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [EW-1:0] elem_cnt_q;
   logic [LW-1:0] lane_q;
   logic [BW-1:0] pack_q;
   logic [BW-1:0] beat_dat;
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          ovf_q;
   logic [BW-1:0] mem_q [Depth];

   logic [DataWidth-1:0] elem;
   logic accept, beat_done, frame_done, wr_en, rd_en;

`ifdef MLP_DRAIN_RELU_EN
   assign elem = result_data_i[DataWidth-1] ? '0 : result_data_i;
`else
   assign elem = result_data_i;
`endif

   // The controller cannot stall, so every element outside Flush is taken.
   assign accept     = result_valid_i && (state_q != StFlush);
   assign beat_done  = accept && (lane_q == LastLane);
   assign frame_done = accept && (elem_cnt_q == LastElem);
   assign wr_en      = beat_done;
   assign rd_en      = out_valid_o && out_ready_i;

   assign frame_ready_o = (state_q == StIdle);
   assign out_valid_o   = (count_q != '0);
   assign out_last_o    = out_valid_o && (rd_ptr_q == LastPtr);
   assign out_data_o    = out_valid_o ? mem_q[rd_ptr_q] : '0;
   assign overflow_o    = ovf_q;

   always_comb begin
      beat_dat = pack_q;
      beat_dat[(Pack-1)*DataWidth +: DataWidth] = elem;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (result_valid_i) state_d = StCollect;
         end
         StCollect: begin
            if (frame_done) state_d = StFlush;
         end
         StFlush: begin
            if (rd_en && out_last_o) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      // FrameLen == 1: the triggering element also ends the frame.
      if (state_q == StIdle && frame_done) state_d = StFlush;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         elem_cnt_q <= '0;
         lane_q     <= '0;
         pack_q     <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         ovf_q      <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            pack_q[int'(lane_q)*DataWidth +: DataWidth] <= elem;
            lane_q     <= (lane_q == LastLane) ? '0 : lane_q + LW'(1);
            elem_cnt_q <= frame_done ? '0 : elem_cnt_q + EW'(1);
         end
         if (result_valid_i && state_q == StFlush) ovf_q <= 1'b1;
         if (wr_en) wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + AW'(1);
         if (rd_en) rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + AW'(1);
         case ({wr_en, rd_en})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset: out_data_o is masked while the buffer is empty.
   always_ff @(posedge clk_i) begin
      if (wr_en) mem_q[wr_ptr_q] <= beat_dat;
   end

endmodule

// File: tb/tb_mlp_result_drain.sv
// Directed bench for mlp_result_drain with a queue-based reference model checked every cycle.
module tb_mlp_result_drain;

   localparam int DW    = 8;
   localparam int FL    = 256;
   localparam int PK    = 4;
   localparam int DEPTH = FL / PK;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic          result_valid_i = 1'b0;
   logic [DW-1:0] result_data_i = '0;
   logic          frame_ready_o;
   logic          out_valid_o;
   logic          out_ready_i = 1'b1;
   logic [31:0]   out_data_o;
   logic          out_last_o;
   logic          overflow_o;

   mlp_result_drain #(.DataWidth(DW), .FrameLen(FL), .Pack(PK)) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .result_valid_i (result_valid_i),
      .result_data_i  (result_data_i),
      .frame_ready_o  (frame_ready_o),
      .out_valid_o    (out_valid_o),
      .out_ready_i    (out_ready_i),
      .out_data_o     (out_data_o),
      .out_last_o     (out_last_o),
      .overflow_o     (overflow_o)
   );

   always #5 clk_i = ~clk_i;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: elements accepted this frame, completed beats not yet drained.
   bit          model_on = 0;
   int          m_elems = 0;
   int          m_rd_beat = 0;
   bit          m_ovf = 0;
   logic [7:0]  m_part [PK];
   logic [31:0] exp_q [$];
   logic [31:0] got_q [$];
   int          last_seen = 0;

   function automatic logic [7:0] model_elem(input logic [7:0] e);
`ifdef MLP_DRAIN_RELU_EN
      return (e >= 8'h80) ? 8'h00 : e;
`else
      return e;
`endif
   endfunction

   always @(negedge clk_i) begin
      if (model_on) begin
         chk("frame_ready", {31'b0, frame_ready_o}, {31'b0, m_elems == 0});
         chk("out_valid", {31'b0, out_valid_o}, {31'b0, exp_q.size() != 0});
         chk("overflow", {31'b0, overflow_o}, {31'b0, m_ovf});
         if (exp_q.size() != 0) begin
            chk("out_data", out_data_o, exp_q[0]);
            chk("out_last", {31'b0, out_last_o}, {31'b0, m_rd_beat == DEPTH - 1});
         end
      end
      if (rst_i) begin
         model_on  = 1;
         m_elems   = 0;
         m_rd_beat = 0;
         m_ovf     = 0;
         exp_q.delete();
      end else if (model_on) begin
         if (result_valid_i) begin
            if (m_elems < FL) begin
               m_part[m_elems % PK] = model_elem(result_data_i);
               if (m_elems % PK == PK - 1)
                  exp_q.push_back({m_part[3], m_part[2], m_part[1], m_part[0]});
               m_elems++;
            end else begin
               m_ovf = 1;
            end
         end
         if (out_valid_o && out_ready_i) begin
            got_q.push_back(out_data_o);
            if (out_last_o) last_seen++;
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            if (m_rd_beat == DEPTH - 1) begin
               m_rd_beat = 0;
               if (m_elems == FL) m_elems = 0;
            end else begin
               m_rd_beat++;
            end
         end
      end
   end

   int ready_mode = 0;  // 0: always ready, 1: stalled, 2: random
   always @(posedge clk_i) begin
      #1;
      case (ready_mode)
         0:       out_ready_i = 1'b1;
         1:       out_ready_i = 1'b0;
         default: out_ready_i = ($urandom_range(0, 2) != 0);
      endcase
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic [31:0] idx_beat(input int b);
      logic [31:0] v;
      for (int k = 0; k < PK; k++) v[k*8 +: 8] = 8'((b * PK + k) % 256);
      return v;
   endfunction

   task automatic send_frame(input bit gaps, input bit relu_vec, input int n, input bit check_first);
      logic [7:0] vec [4];
      vec[0] = 8'h80; vec[1] = 8'h7F; vec[2] = 8'hFF; vec[3] = 8'h01;
      for (int i = 0; i < n; i++) begin
         if (gaps && $urandom_range(0, 2) == 0) begin
            result_valid_i = 1'b0;
            repeat ($urandom_range(1, 3)) step();
         end
         result_valid_i = 1'b1;
         result_data_i  = (relu_vec && i < 4) ? vec[i] : 8'(i % 256);
         step();
         if (check_first && i == 2) chk("no_valid_before_elem3", {31'b0, out_valid_o}, 32'd0);
         if (check_first && i == 3) chk("valid_after_elem3", {31'b0, out_valid_o}, 32'd1);
      end
      result_valid_i = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (!(frame_ready_o && !out_valid_o) && n < 3000) begin
         step();
         n++;
      end
      if (n >= 3000) begin
         tests++;
         fails++;
         $display("FAIL drain_timeout: frame_ready=%0d out_valid=%0d required 1/0", frame_ready_o, out_valid_o);
      end
      step();
   endtask

   task automatic do_reset();
      result_valid_i = 1'b0;
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
   endtask

   initial begin
      repeat (3) step();
      rst_i = 1'b0;
      // Idle holds with nothing arriving.
      for (int i = 0; i < 10; i++) begin
         step();
         chk("idle_ready", {31'b0, frame_ready_o}, 32'd1);
         chk("idle_valid", {31'b0, out_valid_o}, 32'd0);
      end

      // Contiguous frame, always ready.
      got_q.delete(); last_seen = 0; ready_mode = 0;
      send_frame(0, 0, FL, 1);
      wait_idle();
      chk("t1_beats", got_q.size(), DEPTH);
      if (got_q.size() == DEPTH) begin
         chk("t1_beat0", got_q[0], 32'h03020100);
         chk("t1_beat63", got_q[63], 32'hFFFEFDFC);
         for (int b = 0; b < DEPTH; b++) chk("t1_beat", got_q[b], idx_beat(b));
      end
      chk("t1_last_once", last_seen, 1);

      // Whole frame stalled, then overflow pulses during Flush, then drain.
      got_q.delete(); last_seen = 0; ready_mode = 1;
      send_frame(0, 0, FL, 0);
      step();
      chk("t2_full_valid", {31'b0, out_valid_o}, 32'd1);
      chk("t2_not_ready", {31'b0, frame_ready_o}, 32'd0);
      chk("t2_head_data", out_data_o, 32'h03020100);
      result_valid_i = 1'b1; result_data_i = 8'h55;
      repeat (2) step();
      result_valid_i = 1'b0;
      step();
      chk("t2_overflow", {31'b0, overflow_o}, 32'd1);
      ready_mode = 0;
      wait_idle();
      chk("t2_beats", got_q.size(), DEPTH);
      if (got_q.size() == DEPTH)
         for (int b = 0; b < DEPTH; b++) chk("t2_beat", got_q[b], idx_beat(b));
      chk("t2_overflow_sticky", {31'b0, overflow_o}, 32'd1);
      do_reset();
      step();
      chk("t2_overflow_cleared", {31'b0, overflow_o}, 32'd0);

      // Random gaps and random back-pressure.
      got_q.delete(); last_seen = 0; ready_mode = 2;
      send_frame(1, 0, FL, 0);
      wait_idle();
      ready_mode = 0;
      chk("t3_beats", got_q.size(), DEPTH);
      if (got_q.size() == DEPTH)
         for (int b = 0; b < DEPTH; b++) chk("t3_beat", got_q[b], idx_beat(b));
      chk("t3_last_once", last_seen, 1);

      // Sign-boundary elements in beat 0.
      got_q.delete(); last_seen = 0;
      send_frame(0, 1, FL, 0);
      wait_idle();
      chk("t4_beats", got_q.size(), DEPTH);
      if (got_q.size() != 0) begin
`ifdef MLP_DRAIN_RELU_EN
         chk("t4_relu_beat0", got_q[0], 32'h01007F00);
`else
         chk("t4_raw_beat0", got_q[0], 32'h01FF7F80);
`endif
      end

      // Reset after 100 elements, then a clean frame.
      send_frame(0, 0, 100, 0);
      do_reset();
      chk("t5_ready_after_rst", {31'b0, frame_ready_o}, 32'd1);
      chk("t5_valid_after_rst", {31'b0, out_valid_o}, 32'd0);
      step();
      got_q.delete(); last_seen = 0;
      send_frame(0, 0, FL, 0);
      wait_idle();
      chk("t5_beats", got_q.size(), DEPTH);
      if (got_q.size() == DEPTH) begin
         chk("t5_beat0", got_q[0], 32'h03020100);
         chk("t5_beat63", got_q[63], 32'hFFFEFDFC);
      end
      chk("t5_last_once", last_seen, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mlp_result_drain.md
Name: mlp_result_drain

Overview:
- Downstream stage of the MLP controller.
- Captures the 256 result elements streamed out of the activation SRAM while the controller's result_valid is high, and optionally applies ReLU.
- Packs Pack elements per beat into a frame buffer and drains them on a valid/ready output stream with a last flag.
- The controller cannot be back-pressured, so this block absorbs a full frame. It tells the upstream start logic when a new inference may be launched.

Parameters:
- DataWidth, 8, width of one result element (signed two's complement)
- FrameLen, 256, elements per inference result; must be a multiple of Pack
- Pack, 4, elements per output beat; Depth = FrameLen/Pack buffer entries

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- result_valid_i  in  1  one element present on result_data_i this cycle (from controller result_valid)
- result_data_i  in  DataWidth  element from activation SRAM read port, aligned with result_valid_i
- frame_ready_o  out  1  block idle and buffer empty; upstream may assert start
- out_valid_o  out  1  output beat valid
- out_ready_i  in  1  downstream accepts beat
- out_data_o  out  Pack*DataWidth  packed beat; element k of the beat in bits [k*DataWidth +: DataWidth]
- out_last_o  out  1  beat is the final beat of the frame
- overflow_o  out  1  sticky; an element arrived when it could not be accepted

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high. All state updates on posedge clk_i.
- Reset values:
  - state = Idle; all pointers, element counter, pack register and lane index = 0.
  - frame_ready_o = 1, out_valid_o = 0, out_last_o = 0, overflow_o = 0, out_data_o = 0.
  - Reset mid-frame discards all buffered and partially packed data.
- States:
  - Idle: buffer empty.
    - result_valid_i -> Collect.
    - The triggering element is accepted as element 0 in the same cycle.
  - Collect: each result_valid_i cycle stores one element.
    - Element counter elem_cnt runs 0..FrameLen-1.
    - Lane index = elem_cnt mod Pack.
    - Gaps (result_valid_i low) are allowed; the counter holds.
    - Accepting element FrameLen-1 -> Flush.
  - Flush: no capture.
    - result_valid_i here is dropped and sets overflow_o.
    - When the last beat handshakes (out_valid_o & out_ready_i & out_last_o) -> Idle.
- frame_ready_o = (state == Idle); combinational from the state register.
- Packing and buffer write:
  - Elements 0..Pack-2 of a beat go to a pack register.
  - On lane Pack-1, the full beat is written into buffer entry wr_ptr the same cycle, and wr_ptr increments.
  - No partial beat is ever emitted.
- Output:
  - FIFO-style buffer with rd_ptr, wr_ptr and count (0..Depth).
  - out_valid_o = (count != 0); out_data_o = buf[rd_ptr] (registered storage, combinational read).
  - Latency: out_valid_o rises the cycle after the element completing a beat is accepted.
  - Handshake:
    - A beat transfers when out_valid_o & out_ready_i.
    - out_data_o and out_last_o are held stable while out_valid_o & !out_ready_i.
    - The drain runs concurrently with Collect.
  - out_last_o = out_valid_o & (beat index of rd_ptr == Depth-1).
- Simultaneous write and read: count unchanged, both pointers advance.
- Full: count == Depth is reachable only at frame end. Writes never exceed one frame, so no in-frame overflow is possible.
- Wrap-around:
  - Pointers are log2(Depth) bits and wrap at Depth.
  - After each frame, both pointers return to 0 because each frame is exactly Depth beats.
- overflow_o clears only on reset.

Optional Feature:
- Macro MLP_DRAIN_RELU_EN.
- Defined: each element is replaced by 0 if its MSB is 1 before packing, so negative values become 0 and non-negative values pass unchanged. This adds no latency.
- Not defined: elements are packed unmodified. There is no ReLU logic.

Test Plan:
- Reset, then idle: frame_ready_o=1, out_valid_o=0, overflow_o=0 -> state holds indefinitely.
- Contiguous frame, result_data_i = elem index mod 256, out_ready_i=1:
  - 64 beats out; beat 0 = 0x03020100; beat 63 = 0xFFFEFDFC with out_last_o=1.
  - First out_valid_o one cycle after element 3.
  - frame_ready_o returns 1 the cycle after the last handshake.
- Back-pressure: out_ready_i=0 for the whole frame, then 1 -> count reaches 64 with no loss; beats are drained in order and data stays stable while stalled.
- Random gaps on result_valid_i and random out_ready_i -> output sequence identical to the contiguous case; out_last_o is asserted exactly once.
- result_valid_i pulsed during Flush -> element dropped, overflow_o=1 and sticky; frame contents unaffected.
- MLP_DRAIN_RELU_EN defined, input elements 0x80, 0x7F, 0xFF, 0x01 -> beat 0 = 0x01007F00. Without the macro -> 0x01FF7F80.
- rst_i asserted after 100 elements -> next cycle frame_ready_o=1, out_valid_o=0; the next frame starts cleanly at beat 0.
